exec_backend_seq: RTL and testbench
===================================

Name: exec_backend_seq

Overview:
- Parametrised, multi-cycle execute/memory backend for the homebrew RISC-V datapath.
- Accepts one operation per handshake and computes one of:
  - an ALU result (add/sub/logic/compare);
  - an iterative barrel shift, one shift stage per cycle;
  - a byte/half/word load or store to an external asynchronous SRAM, with programmable wait states.
- Sits between the register-read stage and writeback; returns the result over a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; power of two, ≥16.
- LOG2X, 5, log2(XLEN); number of shift stages.
- MEM_WAIT, 1, extra SRAM wait cycles per access (0..7).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block idle and can accept.
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; 10-15 behave as ADD.
- mem_op  in  5  [4] mem enable, [3] write, [2] unsigned load, [1:0] size (00 byte, 01 half, 10 word, 11 illegal).
- operand_a  in  XLEN  ALU source A / address base.
- operand_b  in  XLEN  ALU source B / address offset; shamt = operand_b[LOG2X-1:0].
- store_data  in  XLEN  store data, right-aligned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  ALU/shift result, load data, or store address.
- carry  out  1  carry-out of ADD / not-borrow of SUB; 0 otherwise.
- mem_err  out  1  misaligned or illegal-size memory op; qualified by out_valid.
- sram_addr  out  XLEN  word address (byte address with low log2(XLEN/8) bits cleared).
- sram_wdata  out  XLEN  lane-replicated write data.
- sram_rdata  in  XLEN  read data.
- sram_oe_n  out  1  read strobe, active low.
- sram_we_n  out  1  write strobe, active low.
- sram_be_n  out  XLEN/8  byte-lane enables, active low.

Behaviour:
- FSM states: IDLE, ALU, SHIFT, MEM, DONE.
- in_ready = 1 only in IDLE. Accept occurs at the edge where in_valid & in_ready; operands and ops are registered at that edge.
- Routing after accept:
  - mem_op[4]=1 → MEM. Address = operand_a + operand_b, computed in the accept cycle. alu_op is ignored.
  - mem_op[4]=0 and alu_op in 5..7 → SHIFT.
  - otherwise → ALU.
- ALU: result latched one cycle after accept. Then DONE; out_valid is high in the cycle after accept.
- SLT/SLTU: result = {XLEN-1 zeros, lt}.
- SHIFT:
  - Internally, right shifts only. SLL bit-reverses the operand on entry and the result on exit.
  - Stage k (k = LOG2X-1 down to 0) shifts by 2^k when shamt[k]=1, one stage per cycle.
  - SRA fills with sign bit; SRL/SLL fill with 0.
  - out_valid rises LOG2X+1 cycles after accept (6 for XLEN=32). shamt=0 takes the same latency.
- MEM:
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) or size=11: no strobe is asserted; DONE with mem_err=1, result=address; latency 2 cycles.
  - Legal access: strobes are asserted for MEM_WAIT+1 cycles, starting the cycle after accept.
  - sram_be_n selects the addressed lanes.
  - sram_wdata = byte/half replicated across all lanes.
  - Load data is sampled at the last strobe edge, lane-shifted, and sign- or zero-extended per mem_op[2].
  - Store: result = byte address.
  - out_valid rises MEM_WAIT+2 cycles after accept.
- Strobes are registered outputs; sram_oe_n, sram_we_n and sram_be_n are all 1 outside MEM. sram_we_n and sram_oe_n are never low together.
- DONE: out_valid=1 and result/carry/mem_err are held stable until out_ready. On the out_valid & out_ready edge → IDLE; in_ready is high the next cycle, so there is no same-cycle re-accept.
- Reset (asynchronous, any state, including mid-SHIFT or mid-MEM):
  - FSM → IDLE.
  - in_ready=1, out_valid=0, result=0, carry=0, mem_err=0, sram_addr=0, sram_wdata=0.
  - sram_oe_n=1, sram_we_n=1, sram_be_n=all ones, applied immediately without a clock.
  - An in-flight operation is discarded.
- Arithmetic wraps modulo 2^XLEN. The carry register is updated only by ADD/SUB and cleared by all other ops.

Test Plan:
- ADD 0xFFFF_FFFF + 0x0000_0001 → result 0x0000_0000, carry 1, out_valid one cycle after accept; SUB 5−7 → 0xFFFF_FFFE, carry 0; SLT 0x8000_0000 vs 1 → 1, SLTU → 0.
- SRA 0x8000_0010 by 4 → 0xF800_0001; SRL same → 0x0800_0001; SLL 0x0000_0001 by 31 → 0x8000_0000; each out_valid 6 cycles after accept (XLEN=32); shamt 0 → unchanged, same latency.
- MEM_WAIT=1: LB at 0x103 with sram_rdata 0x80FF_0000 → result 0xFFFF_FF80, sram_be_n 0111, sram_oe_n low for 2 cycles, out_valid at accept+3; LBU → 0x0000_0080; LH at 0x102 → 0xFFFF_80FF.
- SH 0xABCD at 0x202 → sram_wdata 0xABCD_ABCD, sram_be_n 0011, sram_we_n low 2 cycles; result 0x0000_0202. LW at 0x201 → mem_err 1, no strobe asserted, latency 2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, offered in_valid not accepted; release → IDLE, next op accepted the following cycle.
- Assert rst_n low mid-MEM store while sram_we_n=0 → sram_we_n=1 immediately (same cycle, no clock edge), out_valid=0, in_ready=1; the first op after reset behaves normally.

Source files
------------

// File: rtl/exec_backend_seq.sv
// Multi-cycle execute/memory backend: ALU, iterative right-shifter, async SRAM load/store.
// Latency: ALU 1 cycle, shift LOG2X+1, legal memory MEM_WAIT+2, faulting memory 2.
// Backpressure: one op in flight; in_ready only in IDLE, result held in ALU/DONE until out_ready.
module exec_backend_seq #(
    parameter int XLEN     = 32,
    parameter int LOG2X    = 5,
    parameter int MEM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [4:0]        mem_op,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    input  logic [XLEN-1:0]   store_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              carry,
    output logic              mem_err,
    output logic [XLEN-1:0]   sram_addr,
    output logic [XLEN-1:0]   sram_wdata,
    input  logic [XLEN-1:0]   sram_rdata,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [XLEN/8-1:0] sram_be_n
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int KW = (LOG2X > 1) ? $clog2(LOG2X) : 1;

    typedef enum logic [2:0] {IDLE, ALU, SHIFT, MEM, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic [LOG2X-1:0] shamt_q;
    logic [XLEN-1:0]  sh_q;
    logic [KW-1:0]    stage_q;
    logic [XLEN-1:0]  maddr_q;
    logic [1:0]       msize_q;
    logic             munsigned_q;
    logic             mwrite_q;
    logic             mbad_q;
    logic [2:0]       wait_q;

    logic             is_shift;
    logic [XLEN:0]    sum_w, diff_w;
    logic [XLEN-1:0]  alu_res;
    logic             alu_carry;
    logic [XLEN-1:0]  addr_w;
    logic [LB-1:0]    lane_off;
    logic             addr_bad;
    logic [NB-1:0]    lane_mask;
    logic [XLEN-1:0]  wdata_rep;
    int               acc_bytes;
    logic [XLEN-1:0]  sh_step, sh_stage;
    logic [XLEN-1:0]  ld_shift, ld_val;
    logic             ld_fill;
    int               ld_bits;

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
        return r;
    endfunction

    assign is_shift = (alu_op >= 4'd5) && (alu_op <= 4'd7);

    // ALU result and carry straight from the offered operands, latched at accept
    always_comb begin
        sum_w     = {1'b0, operand_a} + {1'b0, operand_b};
        diff_w    = {1'b0, operand_a} + {1'b0, ~operand_b} + {{XLEN{1'b0}}, 1'b1};
        alu_res   = sum_w[XLEN-1:0];
        alu_carry = sum_w[XLEN];
        case (alu_op)
            4'd1: begin alu_res = diff_w[XLEN-1:0]; alu_carry = diff_w[XLEN]; end
            4'd2: begin alu_res = operand_a & operand_b; alu_carry = 1'b0; end
            4'd3: begin alu_res = operand_a | operand_b; alu_carry = 1'b0; end
            4'd4: begin alu_res = operand_a ^ operand_b; alu_carry = 1'b0; end
            4'd8: begin
                alu_res   = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
                alu_carry = 1'b0;
            end
            4'd9: begin
                alu_res   = {{(XLEN-1){1'b0}}, operand_a < operand_b};
                alu_carry = 1'b0;
            end
            default: ;
        endcase
    end

    // Memory address, alignment check, lane enables and replicated write data at accept
    always_comb begin
        addr_w    = operand_a + operand_b;
        lane_off  = addr_w[LB-1:0];
        acc_bytes = 1 << mem_op[1:0];
        addr_bad  = (mem_op[1:0] == 2'b11) ||
                    (mem_op[1:0] == 2'b01 && addr_w[0]) ||
                    (mem_op[1:0] == 2'b10 && addr_w[1:0] != 2'b00);
        lane_mask = '0;
        wdata_rep = '0;
        for (int i = 0; i < NB; i++) begin
            lane_mask[i]        = (i >= int'(lane_off)) && (i < int'(lane_off) + acc_bytes);
            wdata_rep[8*i +: 8] = store_data[8*(i % acc_bytes) +: 8];
        end
    end

    // One barrel stage per cycle: shift right by 2^stage when that shamt bit is set
    always_comb begin
        if (op_q == 4'd7) sh_step = $signed(sh_q) >>> (1 << stage_q);
        else              sh_step = sh_q >> (1 << stage_q);
        sh_stage = shamt_q[stage_q] ? sh_step : sh_q;
    end

    // Load data: move addressed lane to bit 0, then sign- or zero-extend
    always_comb begin
        ld_shift = sram_rdata >> {maddr_q[LB-1:0], 3'b000};
        ld_bits  = 8 << msize_q;
        if (ld_bits > XLEN) ld_bits = XLEN;
        ld_fill  = ~munsigned_q & ld_shift[ld_bits-1];
        ld_val   = ld_shift;
        for (int i = 0; i < XLEN; i++)
            if (i >= ld_bits) ld_val[i] = ld_fill;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; ALU results are already latched so ALU presents them
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == ALU) || (state == DONE);
        case (state)
            IDLE:      if (in_valid) state_nxt = mem_op[4] ? MEM : (is_shift ? SHIFT : ALU);
            ALU, DONE: state_nxt = out_ready ? IDLE : DONE;
            SHIFT:     if (stage_q == '0) state_nxt = DONE;
            MEM:       if (mbad_q || wait_q == 3'd0) state_nxt = DONE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Datapath: capture at accept, step shifter, run SRAM strobes, write result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0; shamt_q <= '0; sh_q <= '0; stage_q <= '0;
            maddr_q <= '0; msize_q <= '0; munsigned_q <= 1'b0; mwrite_q <= 1'b0;
            mbad_q <= 1'b0; wait_q <= '0;
            result <= '0; carry <= 1'b0; mem_err <= 1'b0;
            sram_addr <= '0; sram_wdata <= '0;
            sram_oe_n <= 1'b1; sram_we_n <= 1'b1; sram_be_n <= '1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q    <= alu_op;
                    shamt_q <= operand_b[LOG2X-1:0];
                    mem_err <= 1'b0;
                    carry   <= 1'b0;
                    if (mem_op[4]) begin
                        maddr_q     <= addr_w;
                        msize_q     <= mem_op[1:0];
                        munsigned_q <= mem_op[2];
                        mwrite_q    <= mem_op[3];
                        mbad_q      <= addr_bad;
                        wait_q      <= 3'(MEM_WAIT);
                        sram_addr   <= addr_w & ~XLEN'(NB - 1);
                        sram_wdata  <= wdata_rep;
                        if (!addr_bad) begin
                            sram_oe_n <= mem_op[3];
                            sram_we_n <= ~mem_op[3];
                            sram_be_n <= ~lane_mask;
                        end
                    end else if (is_shift) begin
                        sh_q    <= (alu_op == 4'd5) ? bit_rev(operand_a) : operand_a;
                        stage_q <= KW'(LOG2X - 1);
                    end else begin
                        result <= alu_res;
                        carry  <= alu_carry;
                    end
                end
                SHIFT: begin
                    sh_q    <= sh_stage;
                    stage_q <= stage_q - 1'b1;
                    if (stage_q == '0)
                        result <= (op_q == 4'd5) ? bit_rev(sh_stage) : sh_stage;
                end
                MEM: begin
                    if (mbad_q) begin
                        result  <= maddr_q;
                        mem_err <= 1'b1;
                    end else if (wait_q == 3'd0) begin
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_be_n <= '1;
                        result    <= mwrite_q ? maddr_q : ld_val;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_backend_seq.sv
module tb_exec_backend_seq;
    localparam int XLEN = 32;
    localparam int LOG2X = 5;
    localparam int MEM_WAIT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = '0;
    logic [4:0]  mem_op = '0;
    logic [31:0] operand_a = '0, operand_b = '0, store_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry, mem_err;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic        sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exec_backend_seq #(.XLEN(XLEN), .LOG2X(LOG2X), .MEM_WAIT(MEM_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .mem_op(mem_op), .operand_a(operand_a), .operand_b(operand_b),
        .store_data(store_data), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .mem_err(mem_err),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic        cy;
        logic        err;
        logic        wr;
        logic [7:0]  lat;
        logic [7:0]  strobes;
        logic [3:0]  be_n;
        logic [31:0] wdata;
        logic [31:0] waddr;
    } exp_t;

    // Architectural behaviour of one operation, from the instruction semantics
    function automatic exp_t model(input logic [3:0] op, input logic [4:0] mop,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] sd, input logic [31:0] rd);
        exp_t m;
        logic [32:0] wide;
        logic [31:0] addr, sh;
        int off, nb, mask;
        m = '0;
        if (mop[4]) begin
            addr    = a + b;
            off     = int'(addr % 4);
            nb      = (mop[1:0] == 2'd0) ? 1 : (mop[1:0] == 2'd1) ? 2 : 4;
            m.wr    = mop[3];
            m.waddr = {addr[31:2], 2'b00};
            m.be_n  = 4'hF;
            if (mop[1:0] == 2'd3 || (addr % nb) != 0) begin
                m.err = 1'b1; m.res = addr; m.lat = 8'd2;
            end else begin
                m.lat     = 8'(MEM_WAIT + 2);
                m.strobes = 8'(MEM_WAIT + 1);
                mask      = ((1 << nb) - 1) << off;
                m.be_n    = ~mask[3:0];
                m.wdata   = (nb == 1) ? {4{sd[7:0]}} : (nb == 2) ? {2{sd[15:0]}} : sd;
                if (mop[3]) m.res = addr;
                else begin
                    sh = rd >> (8 * off);
                    if (nb == 1)      m.res = mop[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
                    else if (nb == 2) m.res = mop[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                    else              m.res = sh;
                end
            end
        end else begin
            m.lat = 8'd1;
            case (op)
                4'd1: begin m.res = a - b; m.cy = (a >= b); end
                4'd2: m.res = a & b;
                4'd3: m.res = a | b;
                4'd4: m.res = a ^ b;
                4'd5: begin m.res = a << b[4:0]; m.lat = 8'(LOG2X + 1); end
                4'd6: begin m.res = a >> b[4:0]; m.lat = 8'(LOG2X + 1); end
                4'd7: begin m.res = $signed(a) >>> b[4:0]; m.lat = 8'(LOG2X + 1); end
                4'd8: m.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'd9: m.res = (a < b) ? 32'd1 : 32'd0;
                default: begin wide = {1'b0, a} + {1'b0, b}; m.res = wide[31:0]; m.cy = wide[32]; end
            endcase
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, observe latency/strobes/result, check against the model, then retire it
    task automatic run_op(input logic [3:0] op, input logic [4:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] sd, input logic [31:0] rd,
                          input int hold, output logic [31:0] g_res, output logic g_cy,
                          output logic g_err, output logic [3:0] g_be, output logic [31:0] g_wd,
                          output int g_lat, output int g_stb);
        exp_t m;
        int w;
        logic both_low, wrong_kind;
        logic [31:0] addr_seen;
        m = model(op, mop, a, b, sd, rd);
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        check("in_ready_before_op", in_ready, 1'b1);
        alu_op = op; mem_op = mop; operand_a = a; operand_b = b; store_data = sd;
        sram_rdata = rd; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        operand_a = $urandom; operand_b = $urandom; store_data = $urandom;
        alu_op = 4'($urandom); mem_op = 5'($urandom);
        g_lat = 1; g_stb = 0; g_be = 4'hF; g_wd = '0; addr_seen = '0;
        both_low = 1'b0; wrong_kind = 1'b0;
        while (!out_valid && g_lat < 40) begin
            if (!sram_oe_n || !sram_we_n) begin
                g_stb++; g_be = sram_be_n; g_wd = sram_wdata; addr_seen = sram_addr;
                if (m.wr ? !sram_oe_n : !sram_we_n) wrong_kind = 1'b1;
            end
            if (!sram_oe_n && !sram_we_n) both_low = 1'b1;
            tick();
            g_lat++;
        end
        g_res = result; g_cy = carry; g_err = mem_err;
        check("latency", g_lat, m.lat);
        check("result", result, m.res);
        check("carry", carry, m.cy);
        check("mem_err", mem_err, m.err);
        check("strobe_cycles", g_stb, m.strobes);
        check("strobe_exclusive", both_low, 1'b0);
        check("strobe_kind", wrong_kind, 1'b0);
        check("strobes_idle_done", {sram_oe_n, sram_we_n, sram_be_n}, 6'h3F);
        if (m.strobes != 0) begin
            check("be_n", g_be, m.be_n);
            check("sram_addr", addr_seen, m.waddr);
            if (m.wr) check("wdata", g_wd, m.wdata);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_stable", {out_valid, in_ready, result, carry, mem_err},
                  {1'b1, 1'b0, m.res, m.cy, m.err});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("retire_idle", {out_valid, in_ready}, 2'b01);
    endtask

    logic [31:0] r, wd;
    logic        cy, er;
    logic [3:0]  be;
    int          lat, stb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", {result, carry, mem_err, sram_addr, sram_wdata}, '0);
        check("rst_strobes", {sram_oe_n, sram_we_n, sram_be_n}, 6'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed ALU cases
        run_op(4'd0, 5'd0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("add_wrap_res", r, 32'h0); check("add_wrap_cy", cy, 1'b1); check("add_lat", lat, 1);
        run_op(4'd1, 5'd0, 32'd5, 32'd7, 0, 0, 1, r, cy, er, be, wd, lat, stb);
        check("sub_res", r, 32'hFFFF_FFFE); check("sub_cy", cy, 1'b0);
        run_op(4'd8, 5'd0, 32'h8000_0000, 32'd1, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("slt", r, 32'd1);
        run_op(4'd9, 5'd0, 32'h8000_0000, 32'd1, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("sltu", r, 32'd0);

        // Directed shifts
        run_op(4'd7, 5'd0, 32'h8000_0010, 32'd4, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("sra", r, 32'hF800_0001); check("sra_lat", lat, 6);
        run_op(4'd6, 5'd0, 32'h8000_0010, 32'd4, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("srl", r, 32'h0800_0001);
        run_op(4'd5, 5'd0, 32'h1, 32'd31, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("sll", r, 32'h8000_0000);
        run_op(4'd6, 5'd0, 32'h1234_5678, 32'h20, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("shamt0", r, 32'h1234_5678); check("shamt0_lat", lat, 6);

        // Directed memory
        run_op(4'd0, 5'b10000, 32'h100, 32'd3, 0, 32'h80FF_0000, 0, r, cy, er, be, wd, lat, stb);
        check("lb", r, 32'hFFFF_FF80); check("lb_be", be, 4'b0111);
        check("lb_stb", stb, 2); check("lb_lat", lat, 3);
        run_op(4'd0, 5'b10100, 32'h100, 32'd3, 0, 32'h80FF_0000, 0, r, cy, er, be, wd, lat, stb);
        check("lbu", r, 32'h0000_0080);
        run_op(4'd0, 5'b10001, 32'h100, 32'd2, 0, 32'h80FF_0000, 0, r, cy, er, be, wd, lat, stb);
        check("lh", r, 32'hFFFF_80FF);
        run_op(4'd0, 5'b11001, 32'h200, 32'd2, 32'h1234_ABCD, 0, 0, r, cy, er, be, wd, lat, stb);
        check("sh_wdata", wd, 32'hABCD_ABCD); check("sh_be", be, 4'b0011);
        check("sh_res", r, 32'h202); check("sh_stb", stb, 2);
        run_op(4'd0, 5'b10010, 32'h200, 32'd1, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("lw_mis_err", er, 1'b1); check("lw_mis_stb", stb, 0); check("lw_mis_lat", lat, 2);

        // Backpressure: result held, offered op ignored until release
        alu_op = 4'd4; mem_op = 5'd0; operand_a = 32'hF0F0_1234; operand_b = 32'h0FF0_0001;
        in_valid = 1'b1;
        tick();
        alu_op = 4'd0; operand_a = 32'd3; operand_b = 32'd4;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 32'hFF00_1235});
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {out_valid, in_ready}, 2'b01);
        tick();
        in_valid = 1'b0;
        check("bp_next_op", {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd7});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset during a store strobe
        alu_op = 4'd0; mem_op = 5'b11010; operand_a = 32'h300; operand_b = 32'h0;
        store_data = 32'hDEAD_BEEF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_mid_we_low", sram_we_n, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {sram_oe_n, sram_we_n, sram_be_n}, 6'h3F);
        check("rst_mid_hs", {out_valid, in_ready}, 2'b01);
        check("rst_mid_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(4'd0, 5'd0, 32'd40, 32'd2, 0, 0, 0, r, cy, er, be, wd, lat, stb);
        check("post_rst_add", r, 32'd42);

        // Randomized mix against the model
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  op;
            logic [4:0]  mop;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                mop = {1'b1, 4'($urandom)};
                a   = $urandom & 32'h0000_FFF0;
                b   = $urandom_range(0, 15);
            end else begin
                mop = {1'b0, 4'($urandom)};
                a   = $urandom;
                b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            end
            run_op(op, mop, a, b, $urandom, $urandom, $urandom_range(0, 2),
                   r, cy, er, be, wd, lat, stb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
